// File: rtl/avr_io_pkg.sv
// rtl/avr_io_pkg.sv - IO register map, bit indices and sync depth for avr_pcint
// AVR_PCINT_SYNC_EN selects the two-flop pin synchronizer instead of a single sample stage.
package avr_io_pkg;

    localparam int PCIFR_OFS = 0;
    localparam int PCICR_OFS = 1;
    localparam int PCMSK_OFS = 2;

    localparam int PCIF_BIT = 0;
    localparam int PCIE_BIT = 0;

`ifdef AVR_PCINT_SYNC_EN
    localparam int SYNC_DEPTH = 2;
`else
    localparam int SYNC_DEPTH = 1;
`endif

    // Sample stages plus the prev register must all hold real pin data before detection arms.
    localparam int ARM_COUNT = SYNC_DEPTH + 1;
    localparam int ARM_W     = 2;

    typedef enum logic [1:0] {
        REG_PCIFR = 2'd0,
        REG_PCICR = 2'd1,
        REG_PCMSK = 2'd2,
        REG_NONE  = 2'd3
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [5:0] addr, input logic [5:0] base);
        reg_sel_e sel;
        sel = REG_NONE;
        if (addr == base + 6'(PCIFR_OFS)) begin
            sel = REG_PCIFR;
        end else if (addr == base + 6'(PCICR_OFS)) begin
            sel = REG_PCICR;
        end else if (addr == base + 6'(PCMSK_OFS)) begin
            sel = REG_PCMSK;
        end
        return sel;
    endfunction

endpackage

// File: rtl/avr_pin_sync.sv
// rtl/avr_pin_sync.sv - pin sample/synchronizer chain, prev register and masked change detect
module avr_pin_sync #(
    parameter int PORT_WIDTH = 8,
    parameter int SYNC_DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PORT_WIDTH-1:0] pin_in,
    input  logic [PORT_WIDTH-1:0] pcmsk,
    input  logic                  armed,
    output logic                  change
);

    logic [PORT_WIDTH-1:0] stage_q [SYNC_DEPTH];
    logic [PORT_WIDTH-1:0] stage_d [SYNC_DEPTH];
    logic [PORT_WIDTH-1:0] prev_q;
    logic [PORT_WIDTH-1:0] prev_d;
    logic [PORT_WIDTH-1:0] sampled;

    assign sampled = stage_q[SYNC_DEPTH-1];

    always_comb begin
        stage_d[0] = pin_in;
        for (int i = 1; i < SYNC_DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        // prev tracks every pin so unmasking a pin later never sees a stale level.
        prev_d = sampled;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            prev_q <= prev_d;
        end
    end

    assign change = armed & (|((sampled ^ prev_q) & pcmsk));

endmodule

// File: rtl/avr_pcint.sv
// rtl/avr_pcint.sv - AVR pin-change interrupt: PCIFR/PCICR/PCMSK registers, arming and flag logic
// Build with AVR_PCINT_SYNC_EN defined to add a two-flop synchronizer on pin_in.
module avr_pcint
    import avr_io_pkg::*;
#(
    parameter int IO_ADDR    = 0,
    parameter int PORT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            io_addr,
    inout  wire  [7:0]            io_data,
    input  logic                  io_write,
    input  logic                  io_read,
    input  logic [PORT_WIDTH-1:0] pin_in,
    output logic                  irq,
    input  logic                  irq_ack
);

    localparam logic [5:0] BASE = 6'(IO_ADDR);

    logic                  pcif_q, pcif_d;
    logic                  pcie_q, pcie_d;
    logic [PORT_WIDTH-1:0] pcmsk_q, pcmsk_d;
    logic [7:0]            io_data_out_q, io_data_out_d;
    logic [ARM_W-1:0]      arm_cnt_q, arm_cnt_d;

    logic       armed;
    logic       change;
    logic       flag_clr;
    logic [7:0] wdata;
    logic [7:0] rd_val;
    reg_sel_e   sel;

    assign wdata = io_data;
    assign sel   = decode_addr(io_addr, BASE);
    assign armed = (arm_cnt_q == ARM_W'(ARM_COUNT));

    avr_pin_sync #(
        .PORT_WIDTH (PORT_WIDTH),
        .SYNC_DEPTH (SYNC_DEPTH)
    ) u_pin_sync (
        .clk    (clk),
        .rst    (rst),
        .pin_in (pin_in),
        .pcmsk  (pcmsk_q),
        .armed  (armed),
        .change (change)
    );

    always_comb begin
        rd_val = 8'h00;
        case (sel)
            REG_PCIFR: rd_val[PCIF_BIT] = pcif_q;
            REG_PCICR: rd_val[PCIE_BIT] = pcie_q;
            REG_PCMSK: rd_val = 8'(pcmsk_q);
            default:   rd_val = 8'h00;
        endcase
    end

    always_comb begin
        pcie_d        = pcie_q;
        pcmsk_d       = pcmsk_q;
        io_data_out_d = io_data_out_q;
        arm_cnt_d     = arm_cnt_q;

        if (io_write) begin
            case (sel)
                REG_PCICR: pcie_d  = wdata[PCIE_BIT];
                REG_PCMSK: pcmsk_d = wdata[PORT_WIDTH-1:0];
                default:   ;
            endcase
        end

        if (io_read && sel != REG_NONE) begin
            io_data_out_d = rd_val;
        end

        if (!armed) begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end

        // A new change outranks a same-cycle acknowledge or write-1 so no edge is lost.
        flag_clr = irq_ack | (io_write & (sel == REG_PCIFR) & wdata[PCIF_BIT]);
        if (change) begin
            pcif_d = 1'b1;
        end else if (flag_clr) begin
            pcif_d = 1'b0;
        end else begin
            pcif_d = pcif_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcif_q        <= 1'b0;
            pcie_q        <= 1'b0;
            pcmsk_q       <= '0;
            io_data_out_q <= 8'h00;
            arm_cnt_q     <= '0;
        end else begin
            pcif_q        <= pcif_d;
            pcie_q        <= pcie_d;
            pcmsk_q       <= pcmsk_d;
            io_data_out_q <= io_data_out_d;
            arm_cnt_q     <= arm_cnt_d;
        end
    end

    assign irq     = pcif_q & pcie_q;
    assign io_data = io_read ? io_data_out_q : 8'hzz;

endmodule

// File: tb/tb_avr_pcint.sv
// tb/tb_avr_pcint.sv - randomized self-checking bench for avr_pcint against a cycle-history model
module tb_avr_pcint;

`ifdef AVR_PCINT_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] io_addr;
    logic       io_write;
    logic       io_read;
    logic [7:0] pin_in;
    logic       irq;
    logic       irq_ack;
    logic       drv_en;
    logic [7:0] drv_data;
    wire  [7:0] io_data;

    assign io_data = drv_en ? drv_data : 8'hzz;

    always #5 clk = ~clk;

    avr_pcint #(
        .IO_ADDR    (0),
        .PORT_WIDTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_addr  (io_addr),
        .io_data  (io_data),
        .io_write (io_write),
        .io_read  (io_read),
        .pin_in   (pin_in),
        .irq      (irq),
        .irq_ack  (irq_ack)
    );

    int checks = 0;
    int failures = 0;

    // Model: pin level seen at each posedge since reset release, plus architectural registers.
    logic [7:0] hist[$];
    int         cyc;
    logic       m_pcif, m_pcie;
    logic [7:0] m_pcmsk, m_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pin_at(input int j);
        if (j < 1) return 8'h00;
        return hist[j-1];
    endfunction

    task automatic model_reset();
        hist.delete();
        cyc     = 0;
        m_pcif  = 1'b0;
        m_pcie  = 1'b0;
        m_pcmsk = 8'h00;
        m_rd    = 8'h00;
    endtask

    // One posedge: the edge numbered k sees the pin from edge k-D compared against edge k-D-1,
    // and only once D+1 edges have already passed since release.
    task automatic tick();
        int         k;
        logic       det, clr;
        logic       n_pcif, n_pcie;
        logic [7:0] n_pcmsk, n_rd;
        hist.push_back(pin_in);
        k   = cyc + 1;
        det = (k >= D + 2) && (((pin_at(k-D) ^ pin_at(k-D-1)) & m_pcmsk) != 8'h00);
        clr = irq_ack || (io_write && io_addr == 6'd0 && drv_data[0]);
        n_pcie  = m_pcie;
        n_pcmsk = m_pcmsk;
        if (io_write && io_addr == 6'd1) n_pcie  = drv_data[0];
        if (io_write && io_addr == 6'd2) n_pcmsk = drv_data;
        n_rd = m_rd;
        if (io_read) begin
            case (io_addr)
                6'd0:    n_rd = {7'b0, m_pcif};
                6'd1:    n_rd = {7'b0, m_pcie};
                6'd2:    n_rd = m_pcmsk;
                default: n_rd = m_rd;
            endcase
        end
        n_pcif = det ? 1'b1 : (clr ? 1'b0 : m_pcif);
        @(posedge clk);
        m_pcif  = n_pcif;
        m_pcie  = n_pcie;
        m_pcmsk = n_pcmsk;
        m_rd    = n_rd;
        cyc++;
        #1;
        chk("irq", {31'b0, irq}, {31'b0, m_pcif & m_pcie});
        if (io_read) chk("rdata", {24'b0, io_data}, {24'b0, m_rd});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("irq_in_reset", {31'b0, irq}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        io_addr  = a;
        drv_data = d;
        drv_en   = 1'b1;
        io_write = 1'b1;
        tick();
        io_write = 1'b0;
        drv_en   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [5:0] a, input logic [7:0] exp);
        io_addr = a;
        io_read = 1'b1;
        tick();
        chk(tag, {24'b0, io_data}, {24'b0, exp});
        io_read = 1'b0;
    endtask

    initial begin
        int         n;
        int         op;
        logic [5:0] picks [6];
        picks = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd5, 6'd63};
        rst = 1'b1; io_addr = '0; io_write = 1'b0; io_read = 1'b0;
        irq_ack = 1'b0; drv_en = 1'b0; drv_data = '0; pin_in = 8'hFF;
        #2;
        do_reset();

        // Pins already high at release must not raise the flag.
        wr(6'd2, 8'hFF);
        wr(6'd1, 8'h01);
        repeat (18) tick();
        rd("release_pcifr", 6'd0, 8'h00);

        // Latency through the sample pipeline, then an unmasked pin.
        wr(6'd2, 8'h04);
        pin_in ^= 8'h04;
        n = 0;
        while (!irq && n < 10) begin
            tick();
            n++;
        end
        chk("latency", n, D + 1);
        wr(6'd0, 8'h01);
        chk("w1_clear", {31'b0, irq}, 32'd0);
        pin_in ^= 8'h08;
        repeat (6) tick();
        chk("unmasked_pin", {31'b0, irq}, 32'd0);

        // Write-0 keeps the flag, write-1 clears it.
        pin_in ^= 8'h04;
        repeat (D + 1) tick();
        chk("flag_set", {31'b0, irq}, 32'd1);
        wr(6'd0, 8'h00);
        chk("w0_keep", {31'b0, irq}, 32'd1);
        wr(6'd0, 8'h01);
        chk("w1_clear2", {31'b0, irq}, 32'd0);

        // Acknowledge on the detection edge loses to the set.
        pin_in ^= 8'h04;
        repeat (D + 1) tick();
        pin_in ^= 8'h04;
        repeat (D) tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("ack_set_wins", {31'b0, irq}, 32'd1);

        // Flag latches while disabled; enabling later raises irq.
        wr(6'd1, 8'h00);
        wr(6'd0, 8'h01);
        pin_in ^= 8'h04;
        repeat (D + 1) tick();
        chk("disabled_irq", {31'b0, irq}, 32'd0);
        rd("pcif_latched", 6'd0, 8'h01);
        wr(6'd1, 8'h01);
        chk("enable_irq", {31'b0, irq}, 32'd1);
        rd("read_pcmsk", 6'd2, 8'h04);
        rd("read_pcifr", 6'd0, 8'h01);
        rd("read_unmapped_keeps", 6'd9, 8'h01);

        // Asynchronous reset drops irq and clears all registers.
        do_reset();
        rd("rst_pcifr", 6'd0, 8'h00);
        rd("rst_pcicr", 6'd1, 8'h00);
        rd("rst_pcmsk", 6'd2, 8'h00);

        wr(6'd2, 8'($urandom));
        wr(6'd1, 8'h01);
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            if ($urandom_range(0, 2) == 0) pin_in ^= 8'($urandom);
            irq_ack = ($urandom_range(0, 7) == 0);
            op = $urandom_range(0, 5);
            io_addr = picks[$urandom_range(0, 5)];
            if (op == 0) begin
                drv_data = 8'($urandom);
                drv_en   = 1'b1;
                io_write = 1'b1;
            end else if (op == 1) begin
                io_read = 1'b1;
            end
            tick();
            io_write = 1'b0;
            io_read  = 1'b0;
            drv_en   = 1'b0;
            irq_ack  = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
